// File: rtl/idx_loop_gen_if.sv
// Bundle of the index generator's control, size and index signals.
// Optional step counter output exists only when IDX_LOOP_GEN_STEPCNT_EN is defined.
interface idx_loop_gen_if #(
  parameter int IDX_W = 6,
  parameter int SZ_W  = 5
);
  logic             start_i;
  logic             abort_i;
  logic [SZ_W-1:0]  sz_x_i;
  logic [SZ_W-1:0]  sz_y_i;
  logic             adv_i;
  logic [IDX_W-1:0] x_o;
  logic [IDX_W-1:0] y_o;
  logic             valid_o;
  logic             last_x_o;
  logic             last_y_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
`ifdef IDX_LOOP_GEN_STEPCNT_EN
  logic [2*SZ_W-1:0] step_cnt_o;

  modport master (
    output start_i, abort_i, sz_x_i, sz_y_i, adv_i,
    input  x_o, y_o, valid_o, last_x_o, last_y_o, busy_o, done_o, err_o, step_cnt_o
  );
  modport slave (
    input  start_i, abort_i, sz_x_i, sz_y_i, adv_i,
    output x_o, y_o, valid_o, last_x_o, last_y_o, busy_o, done_o, err_o, step_cnt_o
  );
`else
  modport master (
    output start_i, abort_i, sz_x_i, sz_y_i, adv_i,
    input  x_o, y_o, valid_o, last_x_o, last_y_o, busy_o, done_o, err_o
  );
  modport slave (
    input  start_i, abort_i, sz_x_i, sz_y_i, adv_i,
    output x_o, y_o, valid_o, last_x_o, last_y_o, busy_o, done_o, err_o
  );
`endif
endinterface

// File: rtl/idx_loop_gen.sv
// Two-level (x inner, y outer) raster index generator with back-pressure.
// Define IDX_LOOP_GEN_STEPCNT_EN to add the accepted-step counter output.
module idx_loop_gen #(
  parameter int IDX_W = 6,
  parameter int SZ_W  = 5
) (
  input  logic           clk,
  input  logic           rstn,
  idx_loop_gen_if.slave  bus,
  output logic [1:0]     dbg_state
);

  generate
    if (IDX_W < SZ_W) begin : g_bad_width
      $error("idx_loop_gen: IDX_W must be >= SZ_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] x_q, x_d, y_q, y_d;
  logic [SZ_W-1:0]  sz_x_q, sz_x_d, sz_y_q, sz_y_d;
  logic             err_q, err_d;
  logic [SZ_W:0]    term_x, term_y;
  logic             last_x, last_y;
`ifdef IDX_LOOP_GEN_STEPCNT_EN
  logic [2*SZ_W-1:0] cnt_q, cnt_d;
`endif

  // Handshake: the pair on x_o/y_o is transferred on every rising edge where
  // valid_o and adv_i are both high and abort_i is low; otherwise it holds.
  always_comb begin
    term_x = {1'b0, sz_x_q} - {{SZ_W{1'b0}}, 1'b1};
    term_y = {1'b0, sz_y_q} - {{SZ_W{1'b0}}, 1'b1};
    last_x = (state_q == ST_RUN) &&
             ({1'b0, x_q} == {{(IDX_W-SZ_W){1'b0}}, term_x});
    last_y = (state_q == ST_RUN) &&
             ({1'b0, y_q} == {{(IDX_W-SZ_W){1'b0}}, term_y});
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sz_x_d  = sz_x_q;
    sz_y_d  = sz_y_q;
    err_d   = 1'b0;
`ifdef IDX_LOOP_GEN_STEPCNT_EN
    cnt_d   = cnt_q;
`endif
    if (bus.abort_i) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
`ifdef IDX_LOOP_GEN_STEPCNT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            if ((bus.sz_x_i != '0) && (bus.sz_y_i != '0)) begin
              state_d = ST_RUN;
              sz_x_d  = bus.sz_x_i;
              sz_y_d  = bus.sz_y_i;
              x_d     = '0;
              y_d     = '0;
`ifdef IDX_LOOP_GEN_STEPCNT_EN
              cnt_d   = '0;
`endif
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.adv_i) begin
`ifdef IDX_LOOP_GEN_STEPCNT_EN
            cnt_d = cnt_q + {{(2*SZ_W-1){1'b0}}, 1'b1};
`endif
            if (last_x && last_y) begin
              state_d = ST_DONE;
              x_d     = '0;
              y_d     = '0;
            end else if (last_x) begin
              x_d = '0;
              y_d = y_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
              x_d = x_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sz_x_q  <= '0;
      sz_y_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sz_x_q  <= sz_x_d;
      sz_y_q  <= sz_y_d;
      err_q   <= err_d;
    end
  end

`ifdef IDX_LOOP_GEN_STEPCNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.step_cnt_o = cnt_q;
`endif

  assign bus.x_o      = x_q;
  assign bus.y_o      = y_q;
  assign bus.valid_o  = (state_q == ST_RUN);
  assign bus.last_x_o = last_x;
  assign bus.last_y_o = last_y;
  assign bus.busy_o   = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.err_o    = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_idx_loop_gen.sv
// Randomized scoreboard bench for idx_loop_gen: a raster-order model fills the
// expected queue at each start, a negedge monitor pops on every transfer/pulse.
module tb_idx_loop_gen;
  localparam int IDX_W = 6;
  localparam int SZ_W  = 5;
  localparam int EW    = 2 + 2*IDX_W + 2;
  localparam logic [1:0] TAG_PAIR = 2'd0;
  localparam logic [1:0] TAG_DONE = 2'd1;
  localparam logic [1:0] TAG_ERR  = 2'd2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  idx_loop_gen_if #(.IDX_W(IDX_W), .SZ_W(SZ_W)) bus ();

  idx_loop_gen #(.IDX_W(IDX_W), .SZ_W(SZ_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] tag, input int x, input int y,
                                       input bit lx, input bit ly);
    return {tag, IDX_W'(x), IDX_W'(y), lx, ly};
  endfunction

  // Reference model: a run of sx*sy pairs in raster order, then a done pulse.
  task automatic model_start(input int sx, input int sy);
    if (sx == 0 || sy == 0) begin
      exp_q.push_back(mk(TAG_ERR, 0, 0, 1'b0, 1'b0));
    end else begin
      for (int y = 0; y < sy; y++)
        for (int x = 0; x < sx; x++)
          exp_q.push_back(mk(TAG_PAIR, x, y, x == sx-1, y == sy-1));
      exp_q.push_back(mk(TAG_DONE, 0, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic pop_check(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected event %0h expected none at %0t", name, got, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(got), 32'(e));
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.valid_o && bus.adv_i && !bus.abort_i)
        pop_check("pair", {TAG_PAIR, bus.x_o, bus.y_o, bus.last_x_o, bus.last_y_o});
      if (bus.done_o)
        pop_check("done", mk(TAG_DONE, 0, 0, 1'b0, 1'b0));
      if (bus.err_o)
        pop_check("err", mk(TAG_ERR, 0, 0, 1'b0, 1'b0));
      check("busy", 32'(bus.busy_o), 32'(bus.valid_o | bus.done_o));
      if (!bus.valid_o)
        check("last_idle", 32'({bus.last_x_o, bus.last_y_o}), 32'(0));
    end
  end

  // driver tasks: each begins and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int sx, input int sy, input int mode, input int abort_at,
                        input bit poke_done);
    int acc = 0;
    int cyc = 0;
    int total = sx * sy;
    bit a;
    bus.start_i = 1'b1;
    bus.sz_x_i  = SZ_W'(sx);
    bus.sz_y_i  = SZ_W'(sy);
    model_start(sx, sy);
    tick();
    bus.start_i = 1'b0;
    bus.sz_x_i  = SZ_W'($urandom);
    bus.sz_y_i  = SZ_W'($urandom);
    if (total == 0) begin
      check("err_busy", 32'(bus.busy_o), 32'(0));
      check("err_valid", 32'(bus.valid_o), 32'(0));
      tick();
      check("err_busy2", 32'(bus.busy_o), 32'(0));
      check("err_valid2", 32'(bus.valid_o), 32'(0));
      return;
    end
    check("start_valid", 32'(bus.valid_o), 32'(1));
    check("start_xy", 32'({bus.x_o, bus.y_o}), 32'(0));
    while (acc < total && cyc < 4*total + 20) begin
      if (acc == abort_at) begin
        bus.abort_i = 1'b1;
        bus.adv_i   = 1'b1;
        exp_q.delete();
        tick();
        bus.abort_i = 1'b0;
        bus.adv_i   = 1'b0;
        check("abort_valid", 32'(bus.valid_o), 32'(0));
        check("abort_busy", 32'(bus.busy_o), 32'(0));
        check("abort_done", 32'(bus.done_o), 32'(0));
        check("abort_xy", 32'({bus.x_o, bus.y_o}), 32'(0));
        tick();
        tick();
        return;
      end
      case (mode)
        0:       a = 1'b1;
        1:       a = (cyc % 2 == 0);
        default: a = 1'($urandom_range(0, 1));
      endcase
      bus.adv_i = a;
      tick();
      acc += int'(a);
      cyc++;
    end
    bus.adv_i = 1'b0;
    if (acc < total) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: got %0d accepts expected %0d", acc, total);
      exp_q.delete();
      bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      return;
    end
    check("done_pulse", 32'(bus.done_o), 32'(1));
    check("done_valid", 32'(bus.valid_o), 32'(0));
`ifdef IDX_LOOP_GEN_STEPCNT_EN
    check("step_cnt", 32'(bus.step_cnt_o), 32'(total));
`endif
    if (poke_done) begin
      bus.start_i = 1'b1;
      bus.sz_x_i  = SZ_W'(1);
      bus.sz_y_i  = SZ_W'(1);
    end
    tick();
    bus.start_i = 1'b0;
    check("after_done_busy", 32'(bus.busy_o), 32'(0));
    check("after_done_valid", 32'(bus.valid_o), 32'(0));
    check("after_done_done", 32'(bus.done_o), 32'(0));
`ifdef IDX_LOOP_GEN_STEPCNT_EN
    check("step_cnt_hold", 32'(bus.step_cnt_o), 32'(total));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xy"}, 32'({bus.x_o, bus.y_o}), 32'(0));
    check({tag, "_flags"}, 32'({bus.valid_o, bus.last_x_o, bus.last_y_o,
                                bus.busy_o, bus.done_o, bus.err_o}), 32'(0));
  endtask

  task automatic reset_mid(input int sx, input int sy, input int k);
    bus.start_i = 1'b1;
    bus.sz_x_i  = SZ_W'(sx);
    bus.sz_y_i  = SZ_W'(sy);
    model_start(sx, sy);
    tick();
    bus.start_i = 1'b0;
    bus.adv_i   = 1'b1;
    repeat (k) tick();
    bus.adv_i = 1'b0;
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    tick();
    check_reset_outputs("async_rst_held");
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    int sx, sy, ab, total;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.adv_i   = 1'b0;
    bus.sz_x_i  = '0;
    bus.sz_y_i  = '0;
    #3;
    check_reset_outputs("reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();

    do_run(3, 2, 0, -1, 1'b0);
    do_run(3, 2, 1, -1, 1'b1);
    do_run(0, 4, 0, -1, 1'b0);
    do_run(5, 0, 0, -1, 1'b0);
    do_run(31, 31, 0, -1, 1'b0);
    do_run(4, 4, 2, 5, 1'b0);
    do_run(1, 1, 0, -1, 1'b0);
    reset_mid(4, 3, 4);
    do_run(2, 2, 0, -1, 1'b1);
    do_run(31, 1, 2, -1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      sx = $urandom_range(0, 7);
      sy = $urandom_range(0, 7);
      total = sx * sy;
      ab = (total > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, total-1) : -1;
      do_run(sx, sy, $urandom_range(0, 2), ab, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
